pb_io_timer_hub: RTL and testbench
==================================

Name: pb_io_timer_hub

Overview:
Parametrised PicoBlaze peripheral hub that replaces the hard-wired 1 Hz interrupt and single input-port mux used in our template designs.
- Provides NUM_TIMERS programmable millisecond interval timers with enable, mask, write-1-to-clear status and overrun flags.
- Drives the processor interrupt line using the interrupt/interrupt_ack handshake.
- Provides a registered, pipelined input-port mux over NUM_IN_PORTS external byte inputs.
- Sits between the pacoblaze3 core and board I/O. LED/LCD output registers stay in the top level.

Parameters:
- CLK_FREQ_IN_HZ, 25000000: system clock frequency. TICK_DIV = CLK_FREQ_IN_HZ/1000 gives a 1 ms tick.
- NUM_TIMERS, 2: number of interval timers, range 1..4.
- NUM_IN_PORTS, 4: number of external input bytes, range 1..8.
- BASE_ADDR, 8'hF0: hub register block base. Decode uses port_id[7:4] == BASE_ADDR[7:4].

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- port_id, input, 8: processor port address.
- out_port, input, 8: processor write data.
- write_strobe, input, 1: write qualifier, one cycle.
- read_strobe, input, 1: read qualifier. Informational only; reads have no side effects.
- in_port, output, 8: registered read data to the processor.
- interrupt, output, 1: interrupt request.
- interrupt_ack, input, 1: interrupt acknowledge from the core.
- input_data, input, 8*NUM_IN_PORTS: external inputs. Byte k is input_data[8k+7:8k].
- timer_event, output, NUM_TIMERS: one-cycle pulse when timer i fires.

Behaviour:
Reset values (reset_n low): all registers, counters, prescaler, in_port, interrupt and timer_event are 0.

Register map (offset = port_id[3:0] when the hub is hit):
- 0 CTRL, rw: bit i enables timer i.
- 1 MASK, rw: bit i allows timer i to raise the interrupt.
- 2 STATUS: read returns pending[i]. Writing 1 clears that bit (W1C).
- 3 OVERRUN: read returns overrun[i]. W1C.
- 4+2i RELOAD_LO(i): write stages the low byte. Read returns the committed low byte.
- 5+2i RELOAD_HI(i): write commits {out_port, staged_lo} to reload R_i and loads counter C_i <= R_i. Read returns the committed high byte.
- Unused bits and unused offsets read 0. Writes to them are ignored.

Register writes:
- A write occurs only when write_strobe=1 and the address hits.
- The write takes effect at that clock edge.

Prescaler:
- Free-running counter 0..TICK_DIV-1. tick=1 in the cycle the count equals TICK_DIV-1.
- Never reset by software.

Timer i, evaluated each cycle:
- CTRL[i] 0->1 transition: C_i <= R_i.
- Else if enabled, tick=1 and R_i != 0:
  - If C_i == 1: fire and C_i <= R_i.
  - Else: C_i <= C_i - 1.
- R_i == 0 never fires.
- Period is R_i ticks. First event after enable arrives within ((R_i-1)*TICK_DIV, R_i*TICK_DIV] cycles.

Fire (same cycle):
- timer_event[i] pulses for 1 cycle.
- pending[i] is set.
- If pending[i] was already 1, overrun[i] is set.
- A set from a fire wins over a same-cycle W1C of the same bit.

Interrupt:
- Set on any cycle where (fire & MASK) != 0.
- Cleared on interrupt_ack=1.
- Set wins over a same-cycle ack.
- Does not re-assert from already-pending bits. Software polls STATUS.
- Changing MASK does not retroactively raise the interrupt.

Reads (pipelined, 1-cycle latency):
- in_port <= hub register when the hub is hit.
- in_port <= input_data byte port_id when port_id < NUM_IN_PORTS.
- in_port <= 0 otherwise.
- Computed every cycle regardless of read_strobe.

Reset mid-operation: reset_n low at any time immediately zeroes all state, including counters and staged_lo.

Optional Feature:
PB_IO_SYNC_EN
- Defined: input_data passes through a two-flop synchroniser (reset to 0) before the mux. in_port reflects external changes 2 cycles later than without it. Port read latency from port_id is unchanged at 1 cycle.
- Undefined: input_data goes directly to the mux.

Test Plan:
All scenarios use CLK_FREQ_IN_HZ=10000 (TICK_DIV=10), NUM_TIMERS=2, NUM_IN_PORTS=4.
1. Reset: hold reset_n low, then release. interrupt=0, timer_event=0, in_port=00. Reading 0xF0..0xF7 returns 00.
2. Timer fire: write F4=03, F5=00, F1=01, F0=01. First timer_event[0] arrives 21..30 cycles after the CTRL write, then every 30 cycles. interrupt=1 and STATUS (F2) reads 01.
3. Ack and clear: after interrupt=1, pulse interrupt_ack. interrupt=0 next cycle and F2 still reads 01. Write F2=01; F2 reads 00.
4. Overrun and mask: leave STATUS uncleared for two periods; F3 reads 01, W1C clears it. With MASK=00, timer 1 (R=2) fires and sets STATUS bit1 but interrupt stays 0.
5. Input mux: set input byte 2 = A5, port_id=02, and in_port=A5 one cycle later. port_id=37 gives in_port=00. With PB_IO_SYNC_EN defined, a change to byte 2 appears on in_port 2 cycles later than without it.
6. Collisions: interrupt_ack in the same cycle as a masked fire keeps interrupt=1. A W1C of F2 bit0 in the same cycle as a timer-0 fire leaves pending[0]=1.

Source files
------------

// File: rtl/pb_io_timer_hub.sv
// rtl/pb_io_timer_hub.sv - PicoBlaze millisecond interval timers, interrupt and input-port mux hub
// Optional feature macro: PB_IO_SYNC_EN (two-flop synchroniser on input_data ahead of the read mux).
module pb_io_timer_hub #(
    parameter int         CLK_FREQ_IN_HZ = 25000000,
    parameter int         NUM_TIMERS     = 2,
    parameter int         NUM_IN_PORTS   = 4,
    parameter logic [7:0] BASE_ADDR      = 8'hF0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                port_id,
    input  logic [7:0]                out_port,
    input  logic                      write_strobe,
    input  logic                      read_strobe,
    output logic [7:0]                in_port,
    output logic                      interrupt,
    input  logic                      interrupt_ack,
    input  logic [8*NUM_IN_PORTS-1:0] input_data,
    output logic [NUM_TIMERS-1:0]     timer_event
);
    localparam int TICK_DIV = CLK_FREQ_IN_HZ / 1000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0]         presc;
    logic                      tick;
    logic [NUM_TIMERS-1:0]     ctrl, mask, pending, overrun;
    logic [NUM_TIMERS-1:0]     fire, load, clr_pend, clr_ovr;
    logic [15:0]               reload    [NUM_TIMERS];
    logic [15:0]               count     [NUM_TIMERS];
    logic [7:0]                staged_lo [NUM_TIMERS];
    logic [8*NUM_IN_PORTS-1:0] in_data;
    logic                      hub_hit, wr_hit;
    logic [3:0]                offset;
    logic [7:0]                rd_data;
    logic                      unused_read_strobe;

    assign unused_read_strobe = read_strobe;
    assign hub_hit  = (port_id[7:4] == BASE_ADDR[7:4]);
    assign offset   = port_id[3:0];
    assign wr_hit   = write_strobe && hub_hit;
    assign tick     = (presc == TICK_LAST);
    assign clr_pend = (wr_hit && offset == 4'd2) ? out_port[NUM_TIMERS-1:0] : '0;
    assign clr_ovr  = (wr_hit && offset == 4'd3) ? out_port[NUM_TIMERS-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

`ifdef PB_IO_SYNC_EN
    logic [8*NUM_IN_PORTS-1:0] sync_q1, sync_q2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= input_data;
            sync_q2 <= sync_q1;
        end
    end
    assign in_data = sync_q2;
`else
    assign in_data = input_data;
`endif

    // A counter reload (enable edge or RELOAD_HI commit) takes precedence over firing.
    always_comb begin
        fire = '0;
        load = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            load[i] = wr_hit && (((offset == 4'd0) && out_port[i] && !ctrl[i]) ||
                                 (offset == 4'(5 + 2*i)));
            fire[i] = !load[i] && ctrl[i] && tick && (reload[i] != 16'd0) && (count[i] <= 16'd1);
        end
    end
    assign timer_event = fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl      <= '0;
            mask      <= '0;
            pending   <= '0;
            overrun   <= '0;
            interrupt <= 1'b0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                reload[i]    <= '0;
                count[i]     <= '0;
                staged_lo[i] <= '0;
            end
        end else begin
            if (wr_hit && offset == 4'd0) ctrl <= out_port[NUM_TIMERS-1:0];
            if (wr_hit && offset == 4'd1) mask <= out_port[NUM_TIMERS-1:0];
            pending <= (pending & ~clr_pend) | fire;
            overrun <= (overrun & ~clr_ovr) | (fire & pending);
            if (|(fire & mask))   interrupt <= 1'b1;
            else if (interrupt_ack) interrupt <= 1'b0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr_hit && offset == 4'(4 + 2*i)) staged_lo[i] <= out_port;
                if (wr_hit && offset == 4'(5 + 2*i)) begin
                    reload[i] <= {out_port, staged_lo[i]};
                    count[i]  <= {out_port, staged_lo[i]};
                end else if (load[i] || fire[i]) begin
                    count[i] <= reload[i];
                end else if (ctrl[i] && tick && reload[i] != 16'd0) begin
                    count[i] <= count[i] - 16'd1;
                end
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (hub_hit) begin
            case (offset)
                4'd0:    rd_data[NUM_TIMERS-1:0] = ctrl;
                4'd1:    rd_data[NUM_TIMERS-1:0] = mask;
                4'd2:    rd_data[NUM_TIMERS-1:0] = pending;
                4'd3:    rd_data[NUM_TIMERS-1:0] = overrun;
                default: rd_data = 8'h00;
            endcase
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (offset == 4'(4 + 2*i)) rd_data = reload[i][7:0];
                if (offset == 4'(5 + 2*i)) rd_data = reload[i][15:8];
            end
        end else begin
            for (int k = 0; k < NUM_IN_PORTS; k++) begin
                if (port_id == 8'(k)) rd_data = in_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) in_port <= 8'h00;
        else          in_port <= rd_data;
    end
endmodule

// File: tb/tb_pb_io_timer_hub.sv
// tb/tb_pb_io_timer_hub.sv - directed, table-driven bench for pb_io_timer_hub
module tb_pb_io_timer_hub;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  port_id = 8'h00;
    logic [7:0]  out_port = 8'h00;
    logic        write_strobe = 1'b0;
    logic        read_strobe = 1'b0;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack = 1'b0;
    logic [31:0] input_data = 32'h0;
    logic [1:0]  timer_event;

    int total = 0;
    int bad = 0;

    pb_io_timer_hub #(
        .CLK_FREQ_IN_HZ(10000),
        .NUM_TIMERS(2),
        .NUM_IN_PORTS(4),
        .BASE_ADDR(8'hF0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .port_id(port_id),
        .out_port(out_port),
        .write_strobe(write_strobe),
        .read_strobe(read_strobe),
        .in_port(in_port),
        .interrupt(interrupt),
        .interrupt_ack(interrupt_ack),
        .input_data(input_data),
        .timer_event(timer_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        port_id = a; out_port = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        port_id = a; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        d = in_port;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(name, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic ctrl_write_and_wait(input logic [7:0] d, input int idx, input int limit, output int n);
        @(negedge clk);
        port_id = 8'hF0; out_port = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; port_id = 8'hF2;
        n = 1;
        while (!timer_event[idx] && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    vec_t vecs[26];
    int n;
    int f;

    initial begin
        for (int i = 0; i < 8; i++) vecs[i] = '{1'b0, 8'hF0 + 8'(i), 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 8'hF1, 8'h03, 8'h00};
        vecs[9]  = '{1'b0, 8'hF1, 8'h00, 8'h03};
        vecs[10] = '{1'b1, 8'hF1, 8'hFF, 8'h00};
        vecs[11] = '{1'b0, 8'hF1, 8'h00, 8'h03};
        vecs[12] = '{1'b1, 8'hF4, 8'h34, 8'h00};
        vecs[13] = '{1'b0, 8'hF4, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 8'hF5, 8'h12, 8'h00};
        vecs[15] = '{1'b0, 8'hF4, 8'h00, 8'h34};
        vecs[16] = '{1'b0, 8'hF5, 8'h00, 8'h12};
        vecs[17] = '{1'b0, 8'hF8, 8'h00, 8'h00};
        vecs[18] = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[19] = '{1'b0, 8'h00, 8'h00, 8'h11};
        vecs[20] = '{1'b0, 8'h01, 8'h00, 8'h22};
        vecs[21] = '{1'b0, 8'h02, 8'h00, 8'hA5};
        vecs[22] = '{1'b0, 8'h03, 8'h00, 8'h3C};
        vecs[23] = '{1'b0, 8'h04, 8'h00, 8'h00};
        vecs[24] = '{1'b0, 8'h37, 8'h00, 8'h00};
        vecs[25] = '{1'b0, 8'hEF, 8'h00, 8'h00};

        // reset
        repeat (3) @(negedge clk);
        check("rst_irq", {15'h0, interrupt}, 16'h0);
        check("rst_event", {14'h0, timer_event}, 16'h0);
        check("rst_in_port", {8'h0, in_port}, 16'h0);
        reset_n = 1'b1;
        input_data = 32'h3CA5_2211;

        for (int i = 0; i < 26; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            else rd_check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end

        // timer 0, reload 3 ticks, masked in
        wr(8'hF4, 8'h03);
        wr(8'hF5, 8'h00);
        wr(8'hF1, 8'h01);
        ctrl_write_and_wait(8'h01, 0, 40, n);
        check_range("first_fire_latency", n, 21, 30);
        @(negedge clk);
        check("irq_after_fire", {15'h0, interrupt}, 16'h1);
        @(negedge clk);
        check("status_after_fire", {8'h0, in_port}, 16'h01);
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        check("irq_after_ack", {15'h0, interrupt}, 16'h0);
        check("status_after_ack", {8'h0, in_port}, 16'h01);
        out_port = 8'h01; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        @(negedge clk);
        check("status_w1c", {8'h0, in_port}, 16'h00);
        repeat (24) @(negedge clk);
        check("no_early_fire", {15'h0, timer_event[0]}, 16'h0);
        @(negedge clk);
        check("period_fire", {15'h0, timer_event[0]}, 16'h1);
        @(negedge clk);
        check("irq_second_fire", {15'h0, interrupt}, 16'h1);

        // third fire collides with W1C of STATUS bit0 and with interrupt_ack
        repeat (29) @(negedge clk);
        check("collide_fire", {15'h0, timer_event[0]}, 16'h1);
        out_port = 8'h01; write_strobe = 1'b1; interrupt_ack = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; interrupt_ack = 1'b0;
        check("ack_vs_fire", {15'h0, interrupt}, 16'h1);
        @(negedge clk);
        check("w1c_vs_fire", {8'h0, in_port}, 16'h01);
        rd_check("overrun_set", 8'hF3, 8'h01);
        wr(8'hF3, 8'h01);
        rd_check("overrun_w1c", 8'hF3, 8'h00);
        wr(8'hF2, 8'h01);
        rd_check("status_clear2", 8'hF2, 8'h00);
        @(negedge clk);
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        check("irq_cleared", {15'h0, interrupt}, 16'h0);
        wr(8'hF0, 8'h00);

        // timer 1 with MASK=00
        wr(8'hF1, 8'h00);
        wr(8'hF6, 8'h02);
        wr(8'hF7, 8'h00);
        ctrl_write_and_wait(8'h02, 1, 30, n);
        check_range("t1_first_fire", n, 11, 20);
        @(negedge clk);
        check("masked_irq", {15'h0, interrupt}, 16'h0);
        @(negedge clk);
        check("t1_status", {8'h0, in_port}, 16'h02);
        wr(8'hF1, 8'h02);
        @(negedge clk);
        check("mask_no_retro", {15'h0, interrupt}, 16'h0);
        f = 0;
        while (!timer_event[1] && f < 25) begin
            @(negedge clk);
            f++;
        end
        check_range("t1_period_wait", f, 1, 20);
        @(negedge clk);
        check("t1_unmasked_irq", {15'h0, interrupt}, 16'h1);

        // asynchronous reset mid-operation, including staged low byte
        wr(8'hF4, 8'h55);
        @(negedge clk);
        port_id = 8'hF6;
        @(negedge clk);
        check("pre_reset_in_port", {8'h0, in_port}, 16'h02);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_in_port", {8'h0, in_port}, 16'h00);
        check("async_rst_irq", {15'h0, interrupt}, 16'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wr(8'hF5, 8'h77);
        rd_check("staged_lo_reset", 8'hF4, 8'h00);
        rd_check("reload_hi_after_rst", 8'hF5, 8'h77);
        rd_check("ctrl_after_rst", 8'hF0, 8'h00);
        rd_check("reload1_after_rst", 8'hF6, 8'h00);

        // input change latency on port 2
        @(negedge clk);
        port_id = 8'h02;
        @(negedge clk);
        @(negedge clk);
        input_data[23:16] = 8'h5A;
        n = 0;
        while (in_port !== 8'h5A && n < 10) begin
            @(negedge clk);
            n++;
        end
`ifdef PB_IO_SYNC_EN
        check("input_change_latency", 16'(n), 16'd3);
`else
        check("input_change_latency", 16'(n), 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
